// File: rtl/instruction_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_ctrl
//  Function : PC sequencing toward a combinational instruction memory, with a
//             2-entry {PC, instruction} buffer toward decode and a sticky fault.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    input  logic        redirectValid,
    input  logic [31:0] redirectPC,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instrOut,
    output logic [31:0] instrPC,
    output logic        fetchFault,
    output logic [31:0] faultPC
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_FAULT = 1'b1;

    localparam logic [1:0]  c_DEPTH     = 2'(FIFO_DEPTH);
    localparam logic [30:0] c_MEM_WORDS = 31'(MEM_WORDS);

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_ent_pc    [2];
    logic [31:0] r_ent_instr [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_fault;
    logic [31:0] r_fault_pc;

    logic        w_in_range;
    logic        w_misaligned;
    logic        w_pop;
    logic        w_fetch_en;
    logic        w_push;
    logic        w_fault_entry;

    // Word index compared at full width so large PCs never alias into range
    assign w_in_range   = ({1'b0, r_pc[31:2]} < c_MEM_WORDS);
    assign w_misaligned = (redirectPC[1:0] != 2'b00);
    assign w_pop        = (r_count != 2'd0) && instrReady;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic; a redirect overrides everything else
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (redirectValid) begin
            w_next_state = w_misaligned ? S_FAULT : S_FETCH;
        end else if (w_fault_entry) begin
            w_next_state = S_FAULT;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_en    = (r_state == S_FETCH);
        w_push        = 1'b0;
        w_fault_entry = 1'b0;
        if (w_fetch_en && !redirectValid) begin
            w_push        = w_in_range && ((r_count < c_DEPTH) || w_pop);
            w_fault_entry = !w_in_range;
        end
    end

    // ------------------------------------------------------------------
    // Fetch PC and buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_ent_pc[i]    <= 32'd0;
                r_ent_instr[i] <= 32'd0;
            end
        end else if (redirectValid) begin
            r_pc     <= redirectPC;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_ent_pc[r_wr_ptr]    <= r_pc;
                r_ent_instr[r_wr_ptr] <= imemData;
                r_wr_ptr              <= ~r_wr_ptr;
                r_pc                  <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky fault; faultPC keeps its last value once the flag clears
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault    <= 1'b0;
            r_fault_pc <= 32'd0;
        end else if (redirectValid) begin
            r_fault <= w_misaligned;
            if (w_misaligned) begin
                r_fault_pc <= redirectPC;
            end
        end else if (w_fault_entry) begin
            r_fault    <= 1'b1;
            r_fault_pc <= r_pc;
        end
    end

    assign imemAddr   = r_pc;
    assign instrValid = (r_count != 2'd0);
    assign instrOut   = r_ent_instr[r_rd_ptr];
    assign instrPC    = r_ent_pc[r_rd_ptr];
    assign fetchFault = r_fault;
    assign faultPC    = r_fault_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_ctrl.sv
`default_nettype none
// Bench for instruction_fetch_ctrl: queue-based reference model on a 64-word
// instance plus directed literal checks, and a 4-word instance for range faults.
module tb_instruction_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        instrReady;

    logic [31:0] imemAddr, imemData, instrOut, instrPC, faultPC;
    logic        instrValid, fetchFault;

    logic [31:0] imemAddr_s, imemData_s, instrOut_s, instrPC_s, faultPC_s;
    logic        instrValid_s, fetchFault_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory word i holds 0xC000_0000 + i; outside 64 words reads garbage
    function automatic logic [31:0] memrd(input logic [31:0] a);
        logic [31:0] idx;
        idx = {2'b00, a[31:2]};
        return (idx < 32'd64) ? (32'hC000_0000 + idx) : 32'hDEAD_BEEF;
    endfunction

    assign imemData   = memrd(imemAddr);
    assign imemData_s = memrd(imemAddr_s);

    instruction_fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(64), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .imemAddr(imemAddr), .imemData(imemData),
        .redirectValid(redirectValid), .redirectPC(redirectPC),
        .instrValid(instrValid), .instrReady(instrReady), .instrOut(instrOut),
        .instrPC(instrPC), .fetchFault(fetchFault), .faultPC(faultPC)
    );

    instruction_fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(4), .FIFO_DEPTH(2)) u_small (
        .clk(clk), .rst_n(rst_n), .imemAddr(imemAddr_s), .imemData(imemData_s),
        .redirectValid(1'b0), .redirectPC(32'h0),
        .instrValid(instrValid_s), .instrReady(1'b1), .instrOut(instrOut_s),
        .instrPC(instrPC_s), .fetchFault(fetchFault_s), .faultPC(faultPC_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (64-word instance) ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fault_pc;
    logic        m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc       = 32'h0;
            m_fault    = 1'b0;
            m_fault_pc = 32'h0;
        end else begin
            m_pop = (mq.size() > 0) && instrReady;
            if (redirectValid) begin
                mq.delete();
                m_pc = redirectPC;
                if (redirectPC[1:0] != 2'b00) begin
                    m_fault    = 1'b1;
                    m_fault_pc = redirectPC;
                end else begin
                    m_fault = 1'b0;
                end
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (!m_fault) begin
                    if ((m_pc >> 2) >= 32'd64) begin
                        m_fault    = 1'b1;
                        m_fault_pc = m_pc;
                    end else if (mq.size() < 2) begin
                        mq.push_back('{pc: m_pc, ins: memrd(m_pc)});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_valid", {31'b0, instrValid}, {31'b0, (mq.size() > 0)});
            if (mq.size() > 0) begin
                chk("model_instrPC", instrPC, mq[0].pc);
                chk("model_instrOut", instrOut, mq[0].ins);
            end
            chk("model_imemAddr", imemAddr, m_pc);
            chk("model_fetchFault", {31'b0, fetchFault}, {31'b0, m_fault});
            chk("model_faultPC", faultPC, m_fault_pc);
        end
    end

    // ---------------- 4-word instance: directed table ----------------
    initial begin : small_checks
        logic [31:0] e_addr [6];
        e_addr = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h10, 32'h10};
        @(posedge rst_n);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("small_imemAddr", imemAddr_s, e_addr[k]);
            if (k < 4) begin
                chk("small_valid", {31'b0, instrValid_s}, 32'd1);
                chk("small_instrPC", instrPC_s, 32'(k * 4));
                chk("small_instrOut", instrOut_s, 32'hC000_0000 + 32'(k));
                chk("small_fault", {31'b0, fetchFault_s}, 32'd0);
            end else begin
                chk("small_valid", {31'b0, instrValid_s}, 32'd0);
                chk("small_fault", {31'b0, fetchFault_s}, 32'd1);
                chk("small_faultPC", faultPC_s, 32'h10);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirectValid = 1'b1;
        redirectPC    = pc;
        step(1);
        redirectValid = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        redirectValid = 1'b0;
        redirectPC    = 32'h0;
        instrReady    = 1'b1;
        step(1);
        chk("rst_valid", {31'b0, instrValid}, 32'd0);
        chk("rst_imemAddr", imemAddr, 32'h0);
        chk("rst_instrOut", instrOut, 32'h0);
        chk("rst_instrPC", instrPC, 32'h0);
        chk("rst_fault", {31'b0, fetchFault}, 32'd0);
        chk("rst_faultPC", faultPC, 32'h0);

        // Stream
        rst_n = 1'b1;
        step(1);
        chk("stream_pc0", instrPC, 32'h0);
        chk("stream_w0", instrOut, 32'hC000_0000);
        step(1);
        chk("stream_pc1", instrPC, 32'h4);
        chk("stream_w1", instrOut, 32'hC000_0001);
        step(6);

        // Backpressure from cycle 1
        rst_n      = 1'b0;
        instrReady = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("bp_imemAddr_park", imemAddr, 32'h8);
        chk("bp_head_pc", instrPC, 32'h0);
        chk("bp_head_w", instrOut, 32'hC000_0000);
        instrReady = 1'b1;
        step(1);
        chk("bp_rel_pc1", instrPC, 32'h4);
        step(1);
        chk("bp_rel_pc2", instrPC, 32'h8);
        chk("bp_rel_w2", instrOut, 32'hC000_0002);

        // Redirect with full buffer
        instrReady = 1'b0;
        step(2);
        redirect(32'h14);
        chk("redir_flush_valid", {31'b0, instrValid}, 32'd0);
        step(1);
        chk("redir_head_pc", instrPC, 32'h14);
        chk("redir_head_w", instrOut, 32'hC000_0005);
        instrReady = 1'b1;
        step(1);
        chk("redir_next_pc", instrPC, 32'h18);
        chk("redir_next_w", instrOut, 32'hC000_0006);

        // Misaligned redirect, then recovery
        redirect(32'h6);
        chk("mis_fault", {31'b0, fetchFault}, 32'd1);
        chk("mis_faultPC", faultPC, 32'h6);
        step(2);
        chk("mis_novalid", {31'b0, instrValid}, 32'd0);
        chk("mis_hold_addr", imemAddr, 32'h6);
        redirect(32'h8);
        chk("rec_fault_clr", {31'b0, fetchFault}, 32'd0);
        step(1);
        chk("rec_head_pc", instrPC, 32'h8);
        chk("rec_head_w", instrOut, 32'hC000_0002);

        // Aligned redirect out of range, then the last two words
        redirect(32'h100);
        chk("oor_fault_late", {31'b0, fetchFault}, 32'd0);
        step(1);
        chk("oor_fault", {31'b0, fetchFault}, 32'd1);
        chk("oor_faultPC", faultPC, 32'h100);
        redirect(32'hF8);
        step(1);
        chk("edge_pc62", instrPC, 32'hF8);
        chk("edge_w62", instrOut, 32'hC000_003E);
        step(1);
        chk("edge_pc63", instrPC, 32'hFC);
        step(1);
        chk("edge_fault", {31'b0, fetchFault}, 32'd1);
        chk("edge_faultPC", faultPC, 32'h100);
        chk("edge_novalid", {31'b0, instrValid}, 32'd0);
        step(2);

        // Async reset with a full buffer
        instrReady = 1'b0;
        redirect(32'h0);
        step(2);
        chk("ar_full_pc", instrPC, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, instrValid}, 32'd0);
        chk("ar_fault", {31'b0, fetchFault}, 32'd0);
        chk("ar_imemAddr", imemAddr, 32'h0);
        step(1);
        rst_n      = 1'b1;
        instrReady = 1'b1;
        step(1);
        chk("ar_restart_pc0", instrPC, 32'h0);
        step(1);
        chk("ar_restart_pc1", instrPC, 32'h4);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
